// File: rtl/axi_m_if_pkg.sv
// -----------------------------------------------------------------------------
// axi_m_if_pkg
// Shared AXI4 widths, encodings and FSM state type for the CPU-side AXI
// initiator port (axi_m_if) and its bus interface (axi_m_if_if).
// No ports; import with `import axi_m_if_pkg::*;`.
// -----------------------------------------------------------------------------
package axi_m_if_pkg;

    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = 4;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Every beat is one full 32-bit word.
    localparam logic [AXI_SIZE_BITS-1:0] SIZE_4B = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        WR,
        B
    } axi_m_state_e;

    // Anything other than OKAY counts as a failed response.
    function automatic logic resp_bad(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_m_if_if.sv
// -----------------------------------------------------------------------------
// axi_m_if_if
// The five AXI4 channels (AR, R, AW, W, B) between one initiator and one
// crossbar slave port.
//   modport master : drives AR*/AW*/W* payload+valid, RREADY, BREADY
//   modport slave  : drives ARREADY/AWREADY/WREADY and R*/B* payload+valid
// -----------------------------------------------------------------------------
interface axi_m_if_if;
    import axi_m_if_pkg::*;

    // AR channel
    logic [AXI_ID_BITS-1:0]   arid;
    logic [AXI_ADDR_BITS-1:0] araddr;
    logic [AXI_LEN_BITS-1:0]  arlen;
    logic [AXI_SIZE_BITS-1:0] arsize;
    logic [1:0]               arburst;
    logic                     arvalid;
    logic                     arready;
    // R channel
    logic [AXI_ID_BITS-1:0]   rid;
    logic [AXI_DATA_BITS-1:0] rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;
    // AW channel
    logic [AXI_ID_BITS-1:0]   awid;
    logic [AXI_ADDR_BITS-1:0] awaddr;
    logic [AXI_LEN_BITS-1:0]  awlen;
    logic [AXI_SIZE_BITS-1:0] awsize;
    logic [1:0]               awburst;
    logic                     awvalid;
    logic                     awready;
    // W channel
    logic [AXI_DATA_BITS-1:0] wdata;
    logic [AXI_STRB_BITS-1:0] wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;
    // B channel
    logic [AXI_ID_BITS-1:0]   bid;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_m_if.sv
// -----------------------------------------------------------------------------
// axi_m_if
// AXI4 initiator port: turns a CPU request (single-beat write or INCR burst
// read) into AR/R or AW/W/B transactions, one transaction outstanding.
//
// Ports
//   CPU_CLK_i, CPU_RST_i   clock, synchronous active-high reset
//   req_i/we_i/addr_i/len_i/wdata_i/wstrb_i   CPU request (taken on req_i && ready_o)
//   ready_o                idle, request can be accepted
//   rvalid_o/rdata_o       one-cycle pulse + registered data per read beat
//   done_o                 one-cycle pulse at transaction end
//   err_o/err_clr_i        sticky error flag and its clear
//   axi                    axi_m_if_if.master, the five AXI channels
//
// Build option: define AXI_M_ERR_EN to enable response/ID/beat-count error
// detection on err_o; otherwise err_o is tied low and err_clr_i is ignored.
// -----------------------------------------------------------------------------
module axi_m_if
    import axi_m_if_pkg::*;
#(
    parameter logic [AXI_ID_BITS-1:0] MST_ID = 4'h0
) (
    input  logic                     CPU_CLK_i,
    input  logic                     CPU_RST_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [AXI_ADDR_BITS-1:0] addr_i,
    input  logic [AXI_LEN_BITS-1:0]  len_i,
    input  logic [AXI_DATA_BITS-1:0] wdata_i,
    input  logic [AXI_STRB_BITS-1:0] wstrb_i,
    output logic                     ready_o,
    output logic                     rvalid_o,
    output logic [AXI_DATA_BITS-1:0] rdata_o,
    output logic                     done_o,
    output logic                     err_o,
    input  logic                     err_clr_i,
    axi_m_if_if.master               axi
);

    axi_m_state_e state, state_nx;

    logic [AXI_ADDR_BITS-1:0] addr_q;
    logic [AXI_LEN_BITS-1:0]  len_q;
    logic [AXI_DATA_BITS-1:0] wdata_q;
    logic [AXI_STRB_BITS-1:0] wstrb_q;
    logic [AXI_LEN_BITS-1:0]  beat_cnt;
    logic                     aw_done;
    logic                     w_done;

    logic accept, ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_fin, w_fin;

    // ---------------------------------------------------------------
    // Channel control. VALID/READY come straight from the state
    // register and the per-channel done flags, so no *READY_i ever
    // reaches a *VALID_o combinationally.
    // ---------------------------------------------------------------
    assign ready_o     = (state == IDLE);
    assign axi.arvalid = (state == AR);
    assign axi.rready  = (state == R);
    assign axi.awvalid = (state == WR) && !aw_done;
    assign axi.wvalid  = (state == WR) && !w_done;
    assign axi.bready  = (state == B);

    assign accept = req_i && ready_o;
    assign ar_hs  = axi.arvalid && axi.arready;
    assign r_hs   = axi.rvalid  && axi.rready;
    assign aw_hs  = axi.awvalid && axi.awready;
    assign w_hs   = axi.wvalid  && axi.wready;
    assign b_hs   = axi.bvalid  && axi.bready;

    // AW and W finish independently; either may land first or both together.
    assign aw_fin = aw_done || aw_hs;
    assign w_fin  = w_done  || w_hs;

    // Request payload, held stable from accept until the handshake.
    assign axi.arid    = MST_ID;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = SIZE_4B;
    assign axi.arburst = BURST_INCR;

    assign axi.awid    = MST_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = '0;
    assign axi.awsize  = SIZE_4B;
    assign axi.awburst = BURST_INCR;

    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge CPU_CLK_i) begin
        if (CPU_RST_i) state <= IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (req_i)          state_nx = we_i ? WR : AR;
            AR:   if (axi.arready)    state_nx = R;
            // The burst ends on RLAST only; the beat count is not consulted.
            R:    if (r_hs && axi.rlast) state_nx = IDLE;
            WR:   if (aw_fin && w_fin) state_nx = B;
            B:    if (axi.bvalid)     state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Capture registers, beat counter and CPU-side pulses
    // ---------------------------------------------------------------
    always_ff @(posedge CPU_CLK_i) begin
        if (CPU_RST_i) begin
            addr_q   <= '0;
            len_q    <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            beat_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            done_o   <= 1'b0;

            if (accept) begin
                addr_q  <= addr_i;
                len_q   <= len_i;
                wdata_q <= wdata_i;
                wstrb_q <= wstrb_i;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end

            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;

            if (ar_hs) beat_cnt <= '0;

            if (r_hs) begin
                rdata_o  <= axi.rdata;
                rvalid_o <= 1'b1;
                beat_cnt <= beat_cnt + 4'd1;
                if (axi.rlast) done_o <= 1'b1;
            end

            if (b_hs) done_o <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Error flag
    // ---------------------------------------------------------------
`ifdef AXI_M_ERR_EN
    logic err_set;
    logic err_q;

    // beat_cnt holds the number of beats before the current one, so the
    // RLAST beat is correct exactly when beat_cnt equals the latched len.
    always_comb begin
        err_set = 1'b0;
        if (r_hs && (resp_bad(axi.rresp) || axi.rid != MST_ID ||
                     (axi.rlast && beat_cnt != len_q)))
            err_set = 1'b1;
        if (b_hs && (resp_bad(axi.bresp) || axi.bid != MST_ID))
            err_set = 1'b1;
    end

    // Set has priority over clear in the same cycle.
    always_ff @(posedge CPU_CLK_i) begin
        if (CPU_RST_i)      err_q <= 1'b0;
        else if (err_set)   err_q <= 1'b1;
        else if (err_clr_i) err_q <= 1'b0;
    end

    assign err_o = err_q;
`else
    logic unused_err_inputs;
    assign unused_err_inputs = ^{err_clr_i, axi.rresp, axi.rid,
                                 axi.bresp, axi.bid, beat_cnt};
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_m_if.sv
// -----------------------------------------------------------------------------
// tb_axi_m_if
// Directed + randomized bench for axi_m_if. The bench plays the AXI slave
// and the CPU; expected read data, done pulses and the error flag come from
// the bench's own transaction-level model.
// -----------------------------------------------------------------------------
module tb_axi_m_if;
    import axi_m_if_pkg::*;

    localparam logic [3:0] MID = 4'h5;

    logic        clk = 1'b0;
    logic        rst, req, we, err_clr;
    logic [31:0] addr, wdata;
    logic [3:0]  len, wstrb;
    logic        ready_o, rvalid_o, done_o, err_o;
    logic [31:0] rdata_o;

    always #5 clk = ~clk;

    axi_m_if_if bus();

    axi_m_if #(.MST_ID(MID)) dut (
        .CPU_CLK_i (clk),
        .CPU_RST_i (rst),
        .req_i     (req),
        .we_i      (we),
        .addr_i    (addr),
        .len_i     (len),
        .wdata_i   (wdata),
        .wstrb_i   (wstrb),
        .ready_o   (ready_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .err_clr_i (err_clr),
        .axi       (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_seen;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic        err_exp = 1'b0;

    // Passive collector of CPU-side read beats and done pulses.
    always @(negedge clk) begin
        if (rvalid_o) got_q.push_back(rdata_o);
        if (done_o)   done_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic cpu_req(input logic w, input logic [31:0] a, input logic [3:0] l,
                           input logic [31:0] d, input logic [3:0] s);
        chk("ready_before_req", ready_o, 1);
        req = 1'b1; we = w; addr = a; len = l; wdata = d; wstrb = s;
        step();
        // Scramble the inputs: the DUT must work from its latched copy.
        req = 1'b0; addr = $urandom; len = 4'($urandom); wdata = $urandom; wstrb = 4'($urandom);
        chk("ready_busy", ready_o, 0);
    endtask

    // Model of the sticky flag: any bad response, foreign ID or wrong burst length.
    task automatic model_err(input logic bad);
`ifdef AXI_M_ERR_EN
        if (bad) err_exp = 1'b1;
`else
        if (bad) err_exp = 1'b0;
`endif
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] l, input int ar_dly,
                           input int beats, input logic [1:0] resp, input logic [3:0] id,
                           input int max_gap);
        logic [31:0] d;
        int          gap;
        d = '0;
        done_seen = 0;
        got_q.delete();
        exp_q.delete();
        cpu_req(1'b0, a, l, $urandom, 4'($urandom));
        for (int c = 0; c <= ar_dly; c++) begin
            chk("arvalid_held", bus.arvalid, 1);
            chk("araddr", bus.araddr, a);
            chk("arlen", bus.arlen, l);
            chk("arsize", bus.arsize, SIZE_4B);
            chk("arburst", bus.arburst, BURST_INCR);
            chk("arid", bus.arid, MID);
            chk("rready_in_ar", bus.rready, 0);
            bus.arready = (c == ar_dly);
            step();
        end
        bus.arready = 1'b0;
        chk("arvalid_drop", bus.arvalid, 0);
        for (int b = 0; b < beats; b++) begin
            gap = $urandom_range(max_gap, 0);
            for (int g = 0; g < gap; g++) begin
                chk("rready_gap", bus.rready, 1);
                bus.rvalid = 1'b0;
                // A request while busy must be ignored.
                req = (g == 0); we = 1'b1;
                step();
                req = 1'b0;
                chk("no_aw_while_r", bus.awvalid, 0);
            end
            chk("rready_beat", bus.rready, 1);
            d = $urandom;
            exp_q.push_back(d);
            bus.rvalid = 1'b1; bus.rdata = d; bus.rresp = resp; bus.rid = id;
            bus.rlast = (b == beats - 1);
            step();
            bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rdata = $urandom;
            if (b < beats - 1) chk("done_early", done_o, 0);
        end
        model_err(resp != RESP_OKAY || id != MID || beats != int'(l) + 1);
        chk("last_rvalid", rvalid_o, 1);
        chk("done_with_last", done_o, 1);
        chk("ready_at_done", ready_o, 1);
        chk("rdata_last", rdata_o, d);
        chk("rready_after", bus.rready, 0);
        chk("err_after_read", err_o, err_exp);
        step();
        chk("rvalid_pulse_end", rvalid_o, 0);
        chk("done_pulse_end", done_o, 0);
        chk("beat_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk($sformatf("rdata_seq%0d", k), got_q[k], exp_q[k]);
        chk("done_once_r", done_seen, 1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [1:0] resp, input logic [3:0] id);
        int m;
        m = (aw_dly > w_dly) ? aw_dly : w_dly;
        done_seen = 0;
        cpu_req(1'b1, a, 4'($urandom), d, s);
        for (int c = 0; c <= m; c++) begin
            chk("awvalid", bus.awvalid, c <= aw_dly);
            chk("wvalid", bus.wvalid, c <= w_dly);
            if (c <= aw_dly) begin
                chk("awaddr", bus.awaddr, a);
                chk("awlen", bus.awlen, 0);
                chk("awsize", bus.awsize, SIZE_4B);
                chk("awburst", bus.awburst, BURST_INCR);
                chk("awid", bus.awid, MID);
            end
            if (c <= w_dly) begin
                chk("wdata", bus.wdata, d);
                chk("wstrb", bus.wstrb, s);
                chk("wlast", bus.wlast, 1);
            end
            chk("bready_early", bus.bready, 0);
            bus.awready = (c == aw_dly);
            bus.wready  = (c == w_dly);
            step();
        end
        bus.awready = 1'b0; bus.wready = 1'b0;
        chk("awvalid_done", bus.awvalid, 0);
        chk("wvalid_done", bus.wvalid, 0);
        chk("bready_entered", bus.bready, 1);
        for (int g = 0; g < b_dly; g++) begin
            bus.bvalid = 1'b0;
            step();
            chk("bready_wait", bus.bready, 1);
            chk("done_wait_b", done_o, 0);
        end
        bus.bvalid = 1'b1; bus.bresp = resp; bus.bid = id;
        step();
        bus.bvalid = 1'b0;
        model_err(resp != RESP_OKAY || id != MID);
        chk("done_b", done_o, 1);
        chk("ready_at_done_b", ready_o, 1);
        chk("bready_after", bus.bready, 0);
        chk("err_after_write", err_o, err_exp);
        step();
        chk("done_b_end", done_o, 0);
        chk("done_once_w", done_seen, 1);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        err_exp = 1'b0;
        chk("err_cleared", err_o, 0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; err_clr = 1'b0;
        addr = '0; wdata = '0; len = '0; wstrb = '0;
        bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
        bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rid = '0;
        bus.bvalid = 1'b0; bus.bresp = '0; bus.bid = '0;
        repeat (3) step();

        chk("rst_ready", ready_o, 1);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_awvalid", bus.awvalid, 0);
        chk("rst_wvalid", bus.wvalid, 0);
        chk("rst_rready", bus.rready, 0);
        chk("rst_bready", bus.bready, 0);
        chk("rst_rvalid_o", rvalid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_araddr", bus.araddr, 0);
        chk("rst_wdata", bus.wdata, 0);
        rst = 1'b0;
        step();

        // Read len=3, ARREADY after two cycles.
        do_read(32'h0000_1000, 4'd3, 2, 4, RESP_OKAY, MID, 0);
        // Write, AW accepted at cycle 1, W at cycle 3.
        do_write(32'h0000_2000, 32'hDEADBEEF, 4'hF, 1, 3, 1, RESP_OKAY, MID);
        // Write, AW and W accepted together.
        do_write(32'h0000_3004, $urandom, 4'h3, 0, 0, 0, RESP_OKAY, MID);
        // W before AW.
        do_write(32'h0000_3008, $urandom, 4'hC, 2, 0, 2, RESP_OKAY, MID);
        // Read len=1 with gaps between beats.
        do_read(32'h0000_4000, 4'd1, 0, 2, RESP_OKAY, MID, 3);
        // Single-beat and full 16-beat bursts.
        do_read(32'h0000_5000, 4'd0, 1, 1, RESP_OKAY, MID, 1);
        do_read(32'h0000_6000, 4'd15, 0, 16, RESP_OKAY, MID, 1);

        // Randomized back-to-back traffic.
        for (int i = 0; i < 10; i++) begin
            logic [3:0] l;
            l = 4'($urandom_range(7, 0));
            if ($urandom_range(1, 0) == 1)
                do_write($urandom, $urandom, 4'($urandom), $urandom_range(3, 0),
                         $urandom_range(3, 0), $urandom_range(2, 0), RESP_OKAY, MID);
            else
                do_read($urandom, l, $urandom_range(3, 0), int'(l) + 1, RESP_OKAY, MID, 2);
        end

        // Error detection: bad BRESP, sticky across a clean read, then cleared.
        do_write(32'h0000_7000, $urandom, 4'hF, 0, 0, 0, RESP_SLVERR, MID);
        do_read(32'h0000_7100, 4'd2, 0, 3, RESP_OKAY, MID, 0);
        chk("err_sticky", err_o, err_exp);
        clear_err();
        // RLAST on beat 2 of a len=3 burst.
        do_read(32'h0000_7200, 4'd3, 0, 2, RESP_OKAY, MID, 0);
        clear_err();
        // Foreign RID, and DECERR on read.
        do_read(32'h0000_7300, 4'd1, 0, 2, RESP_OKAY, 4'hA, 0);
        clear_err();
        do_read(32'h0000_7400, 4'd0, 0, 1, RESP_DECERR, MID, 0);
        clear_err();
        do_write(32'h0000_7500, $urandom, 4'h1, 1, 0, 0, RESP_OKAY, 4'h2);
        clear_err();

        // Reset in the middle of a read burst.
        done_seen = 0;
        cpu_req(1'b0, 32'h0000_8000, 4'd7, 32'h0, 4'h0);
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.rvalid = 1'b1; bus.rdata = $urandom; bus.rresp = RESP_OKAY;
            bus.rid = MID; bus.rlast = 1'b0;
            step();
        end
        chk("rready_mid_burst", bus.rready, 1);
        rst = 1'b1;
        step();
        bus.rvalid = 1'b0;
        chk("mid_rst_ready", ready_o, 1);
        chk("mid_rst_rready", bus.rready, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_rvalid_o", rvalid_o, 0);
        chk("mid_rst_arvalid", bus.arvalid, 0);
        rst = 1'b0;
        step();
        chk("mid_rst_no_done", done_o, 0);
        chk("mid_rst_still_idle", ready_o, 1);
        // Port works again after the abort.
        do_read(32'h0000_9000, 4'd2, 0, 3, RESP_OKAY, MID, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
